// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit.
// States, opcodes, ALU op classes and datapath select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    TRAP
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] EXT_I = 2'b00;
  localparam logic [1:0] EXT_S = 2'b01;
  localparam logic [1:0] EXT_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Only add/sub, slt, or and and are implemented for R/I-type.
  function automatic logic funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) ||
           (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the ALU op class and funct fields
// to the ALU control code.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        r_type,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (r_type && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM sequencing the shared
// datapath for lw, sw, R-type, I-type and beq.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] extend_sign,
  output logic       illegal
);

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;
  logic    r_type;
  logic    is_sw;

  assign r_type = (opcode == OP_R);
  assign is_sw  = (opcode == OP_SW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    extend_sign = EXT_I;
    alu_op      = ALU_OP_ADD;
    illegal     = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        // Reset parks us here; keep the Mealy strobes quiet under it.
        ir_write   = mem_ready & ~reset;
        pc_write   = mem_ready & ~reset;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        extend_sign = EXT_B;
        state_d     = TRAP;
        if (opcode == OP_LW || opcode == OP_SW)
          state_d = MEMADR;
        else if (opcode == OP_R && funct3_ok(funct3))
          state_d = EXECR;
        else if (opcode == OP_I && funct3_ok(funct3))
          state_d = EXECI;
        else if (opcode == OP_BR && funct3 == 3'b000)
          state_d = BEQ;
      end
      MEMADR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        extend_sign = is_sw ? EXT_S : EXT_I;
        state_d     = is_sw ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_SUB;
        pc_write  = zero;
        state_d   = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  riscv_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .r_type      (r_type),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for the multi-cycle control unit: per-cycle
// expected outputs are queued by stimulus and popped by a monitor.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, extend_sign;
  logic [2:0] alu_control;
  logic       illegal;

  riscv_multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .extend_sign (extend_sign),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef logic [16:0] vec_t;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  vec_t  mon_exp;
  vec_t  mon_act;
  string mon_name;

  function automatic vec_t mk(input bit pcw, input bit irw,
                              input bit adr, input bit mw,
                              input bit rw, input bit [1:0] rs,
                              input bit [1:0] sa, input bit [1:0] sb,
                              input bit [2:0] ac, input bit [1:0] es,
                              input bit ill);
    return {pcw, irw, adr, mw, rw, rs, sa, sb, ac, es, ill};
  endfunction

  // Fetch-step outputs; strobes equal the handshake outcome.
  function automatic vec_t fetch_v(input bit fire);
    return mk(fire, fire, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
  endfunction

  function automatic bit [2:0] ref_ctl(input bit [2:0] f3,
                                       input bit isr, input bit b5);
    if (f3 == 3'b000) return (isr && b5) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic bit ref_legal(input bit [6:0] op, input bit [2:0] f3);
    bit ok3;
    ok3 = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    if (op == 7'b0000011 || op == 7'b0100011) return 1'b1;
    if (op == 7'b0110011 || op == 7'b0010011) return ok3;
    if (op == 7'b1100011) return f3 == 3'd0;
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit mr, input bit z,
                      input string nm, input vec_t e);
    @(posedge clk);
    #1;
    reset = r;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom), 1'($urandom), "reset", fetch_v(1'b0));
  endtask

  task automatic run_instr(input bit [6:0] op, input bit [2:0] f3,
                           input bit b5, input int fst, input int mst,
                           input bit zv, input bit abort);
    bit [2:0] ctl;
    opcode = op;
    funct3 = f3;
    funct7b5 = b5;
    for (int i = 0; i < fst; i++)
      step(0, 0, 1'($urandom), "fetch_wait", fetch_v(1'b0));
    step(0, 1, 1'($urandom), "fetch", fetch_v(1'b1));
    step(0, 1'($urandom), 1'($urandom), "decode",
         mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0));
    if (!ref_legal(op, f3)) begin
      repeat (3)
        step(0, 1'($urandom), 1'($urandom), "trap",
             mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1));
      do_reset();
      return;
    end
    ctl = ref_ctl(f3, op == 7'b0110011, b5);
    case (op)
      7'b0000011: begin
        step(0, 1'($urandom), 1'($urandom), "memadr_lw",
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
        for (int i = 0; i < mst; i++)
          step(0, 0, 1'($urandom), "memread_wait",
               mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        if (abort) begin
          do_reset();
          return;
        end
        step(0, 1, 1'($urandom), "memread",
             mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
        step(0, 1'($urandom), 1'($urandom), "memwb",
             mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));
      end
      7'b0100011: begin
        step(0, 1'($urandom), 1'($urandom), "memadr_sw",
             mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
        for (int i = 0; i <= mst; i++)
          step(0, i == mst, 1'($urandom), "memwrite",
               mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
      end
      7'b0110011, 7'b0010011: begin
        if (op == 7'b0110011)
          step(0, 1'($urandom), 1'($urandom), "execr",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ctl, 2'b00, 0));
        else
          step(0, 1'($urandom), 1'($urandom), "execi",
               mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ctl, 2'b00, 0));
        step(0, 1'($urandom), 1'($urandom), "aluwb",
             mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
      end
      default: begin
        step(0, 1'($urandom), zv, "beq",
             mk(zv, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0));
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = {pc_write, ir_write, adr_src, mem_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_control,
                    extend_sign, illegal};
        n_tests++;
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h at %0t",
                   mon_name, mon_act, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    bit [6:0] op;
    bit [2:0] f3;
    int       k;
    int       wait_cyc;
    do_reset();
    // Directed cases first.
    run_instr(7'b0000011, 3'd2, 0, 0, 1, 0, 1);
    run_instr(7'b0000011, 3'd2, 0, 0, 0, 0, 0);
    run_instr(7'b0100011, 3'd2, 0, 1, 3, 0, 0);
    run_instr(7'b1100011, 3'd0, 0, 0, 0, 1, 0);
    run_instr(7'b1100011, 3'd0, 0, 0, 0, 0, 0);
    run_instr(7'b0110011, 3'd0, 1, 0, 0, 0, 0);
    run_instr(7'b0010011, 3'd0, 1, 0, 0, 0, 0);
    run_instr(7'b0110011, 3'd6, 0, 0, 0, 0, 0);
    run_instr(7'b0010011, 3'd7, 0, 0, 0, 0, 0);
    run_instr(7'b0110011, 3'd2, 0, 0, 0, 0, 0);
    run_instr(7'b1101111, 3'd0, 0, 0, 0, 0, 0);
    run_instr(7'b0110011, 3'd1, 0, 0, 0, 0, 0);
    run_instr(7'b1100011, 3'd1, 0, 0, 0, 0, 0);
    // Randomized instruction mix with random stalls.
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 9);
      f3 = 3'($urandom);
      case (k)
        0, 1: op = 7'b0000011;
        2, 3: op = 7'b0100011;
        4, 5: op = 7'b0110011;
        6, 7: op = 7'b0010011;
        8: begin
          op = 7'b1100011;
          if ($urandom_range(0, 3) != 0) f3 = 3'd0;
        end
        default: op = 7'($urandom);
      endcase
      run_instr(op, f3, 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom),
                $urandom_range(0, 7) == 0);
    end
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, 0 required", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
